// File: rtl/dbg_step_ctrl_pkg.sv
// Shared encodings for the debug/clock-control unit: operating modes and FSM state codes.
package dbg_step_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10
  } state_e;

endpackage

// File: rtl/dbg_step_ctrl_key.sv
// Step-key conditioning: 2-flop synchroniser, stability counter, rising-edge event.
module key_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic key_evt_o
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             evt_q, evt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      evt_q   <= evt_d;
    end
  end

  // Counter tracks consecutive samples disagreeing with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    evt_d   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        evt_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o   = level_q;
  assign key_evt_o = evt_q;

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug clock-enable controller: halt / divided run / debounced single-step / N-step burst,
// with a probe-channel snapshot register updated after each enable.
//   state    | meaning
//   ST_IDLE  | no enables except single-step on key event; waits for run or burst start
//   ST_RUN   | free-running divider, one enable every div_i+1 cycles
//   ST_BURST | one enable per cycle until the remaining count is spent
module dbg_step_ctrl
  import dbg_step_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 8,
  parameter int SEL_W   = 3,
  parameter int DIV_W   = 8,
  parameter int DEB_CYC = 16,
  parameter int BURST_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode_i,
  input  logic [DIV_W-1:0]         div_i,
  input  logic                     key_i,
  input  logic [BURST_W-1:0]       burst_len_i,
  input  logic [NUM_CH*DATA_W-1:0] probe_i,
  input  logic [SEL_W-1:0]         ch_sel_i,
  input  logic                     freeze_i,
  output logic                     cpu_ce_o,
  output logic                     busy_o,
  output logic [31:0]              step_cnt_o,
  output logic [DATA_W-1:0]        data_o
);

  localparam int NSEL = 2 ** SEL_W;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               ce_q, ce_d;
  logic               busy_q, busy_d;
  logic [31:0]        step_cnt_q, step_cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SEL_W-1:0]   sel_q;
  logic               key_level, key_evt, key_press;
  logic [DATA_W-1:0]  ch_a [NSEL];

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key (
    .clk       (clk),
    .rst       (rst),
    .key_i     (key_i),
    .level_o   (key_level),
    .key_evt_o (key_evt)
  );

  assign key_press = key_evt & key_level;

  // Unpopulated select codes read as zero.
  for (genvar k = 0; k < NSEL; k++) begin : g_ch
    if (k < NUM_CH) begin : g_on
      assign ch_a[k] = probe_i[k*DATA_W +: DATA_W];
    end else begin : g_off
      assign ch_a[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      rem_q      <= '0;
      ce_q       <= 1'b0;
      busy_q     <= 1'b0;
      step_cnt_q <= '0;
      data_q     <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
      step_cnt_q <= step_cnt_d;
      data_q     <= data_d;
      sel_q      <= ch_sel_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    rem_d     = rem_q;
    ce_d      = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        case (mode_e'(mode_i))
          MODE_RUN: begin
            state_d   = ST_RUN;
            div_cnt_d = '0;
          end
          MODE_STEP: ce_d = key_press;
          MODE_BURST: begin
            if (key_press && (burst_len_i != '0)) begin
              state_d = ST_BURST;
              rem_d   = burst_len_i;
              busy_d  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_RUN: begin
        if (mode_e'(mode_i) != MODE_RUN) begin
          state_d = ST_IDLE;
        end else if (div_cnt_q == div_i) begin
          ce_d      = 1'b1;
          div_cnt_d = '0;
        end else if (div_cnt_q > div_i) begin
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_BURST: begin
        if (mode_e'(mode_i) != MODE_BURST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          ce_d  = 1'b1;
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign step_cnt_d = step_cnt_q + {31'b0, ce_q};

  always_comb begin
    data_d = data_q;
    if (!freeze_i && (ce_q || (ch_sel_i != sel_q))) begin
      data_d = ch_a[ch_sel_i];
    end
  end

  assign cpu_ce_o   = ce_q;
  assign busy_o     = busy_q;
  assign step_cnt_o = step_cnt_q;
  assign data_o     = data_q;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Directed bench for dbg_step_ctrl; enable pulses are checked against a queue of expected cycles.
module tb_dbg_step_ctrl;

  localparam int DATA_W  = 32;
  localparam int NUM_CH  = 6;
  localparam int SEL_W   = 3;
  localparam int DIV_W   = 8;
  localparam int DEB_CYC = 16;
  localparam int BURST_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [1:0]               mode_i;
  logic [DIV_W-1:0]         div_i;
  logic                     key_i;
  logic [BURST_W-1:0]       burst_len_i;
  logic [NUM_CH*DATA_W-1:0] probe_i;
  logic [SEL_W-1:0]         ch_sel_i;
  logic                     freeze_i;
  logic                     cpu_ce_o;
  logic                     busy_o;
  logic [31:0]              step_cnt_o;
  logic [DATA_W-1:0]        data_o;

  dbg_step_ctrl #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W),
    .DIV_W(DIV_W), .DEB_CYC(DEB_CYC), .BURST_W(BURST_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode_i),
    .div_i       (div_i),
    .key_i       (key_i),
    .burst_len_i (burst_len_i),
    .probe_i     (probe_i),
    .ch_sel_i    (ch_sel_i),
    .freeze_i    (freeze_i),
    .cpu_ce_o    (cpu_ce_o),
    .busy_o      (busy_o),
    .step_cnt_o  (step_cnt_o),
    .data_o      (data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int e;
  int h, c, nb, first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Run mode for T cycles from now with divider d; queue the cycles that must pulse.
  task automatic run_for(input int d, input int t_len);
    int c0;
    c0 = cyc;
    mode_i = 2'b01;
    div_i  = DIV_W'(d);
    for (int t = c0 + 2 + d; t <= c0 + t_len; t += d + 1) exp_q.push_back(t);
    wait_cyc(t_len);
    mode_i = 2'b00;
  endtask

  task automatic do_reset();
    chk("pending_pulses", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    mode_i = 2'b00;
    key_i = 1'b0;
    freeze_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every enable pulse must match the oldest queued cycle.
  always @(negedge clk) begin
    if (cpu_ce_o === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("pulse_cycle", cyc, e);
    end
  end

  initial begin
    rst = 1'b1;
    mode_i = 2'b00;
    div_i = '0;
    key_i = 1'b0;
    burst_len_i = '0;
    ch_sel_i = '0;
    freeze_i = 1'b0;
    probe_i = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
               32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    chk("init_ce", cpu_ce_o, 0);
    chk("init_busy", busy_o, 0);
    chk("init_steps", step_cnt_o, 0);
    chk("init_data", data_o, 0);

    // Reset mid-run
    c = cyc;
    mode_i = 2'b01;
    div_i = '0;
    for (int t = c + 2; t <= c + 5; t++) exp_q.push_back(t);
    wait_cyc(5);
    chk("run_steps_pre_rst", step_cnt_o, 3);
    chk("run_ce_load", data_o, 32'h1111_1111);
    #2 rst = 1'b1;
    #1;
    chk("rst_ce", cpu_ce_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_steps", step_cnt_o, 0);
    chk("rst_data", data_o, 0);
    mode_i = 2'b00;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(100);
    chk("halt_steps", step_cnt_o, 0);

    // Run mode
    run_for(3, 101);
    wait_cyc(2);
    chk("run_div3_steps", step_cnt_o, 25);
    run_for(0, 11);
    wait_cyc(2);
    chk("run_div0_steps", step_cnt_o, 35);
    c = cyc;
    mode_i = 2'b01;
    div_i = 8'd7;
    wait_cyc(6);
    div_i = 8'd2;
    exp_q.push_back(c + 10);
    exp_q.push_back(c + 13);
    wait_cyc(8);
    mode_i = 2'b00;
    wait_cyc(2);
    chk("run_div_drop_steps", step_cnt_o, 37);

    // Single step with bouncing key, then a short glitch
    do_reset();
    mode_i = 2'b10;
    for (int i = 0; i < 8; i++) begin
      key_i = (i % 2 == 0);
      wait_cyc(5);
    end
    key_i = 1'b1;
    h = cyc;
    exp_q.push_back(h + 19);
    wait_cyc(30);
    chk("step_steps", step_cnt_o, 1);
    key_i = 1'b0;
    wait_cyc(30);
    key_i = 1'b1;
    wait_cyc(10);
    key_i = 1'b0;
    wait_cyc(40);
    chk("glitch_steps", step_cnt_o, 1);

    // Burst of 5
    do_reset();
    mode_i = 2'b11;
    burst_len_i = 8'd5;
    key_i = 1'b1;
    h = cyc;
    for (int t = h + 20; t <= h + 24; t++) exp_q.push_back(t);
    nb = 0;
    first = -1;
    for (int i = 0; i < 30; i++) begin
      wait_cyc(1);
      if (busy_o) begin
        nb++;
        if (first < 0) first = cyc;
      end
    end
    chk("burst_busy_cycles", nb, 5);
    chk("burst_busy_start", first, h + 19);
    key_i = 1'b0;
    wait_cyc(30);
    chk("burst_steps", step_cnt_o, 5);

    // Second press lands inside a long burst
    do_reset();
    mode_i = 2'b11;
    burst_len_i = 8'd60;
    key_i = 1'b1;
    h = cyc;
    for (int t = h + 20; t <= h + 79; t++) exp_q.push_back(t);
    wait_cyc(20);
    key_i = 1'b0;
    wait_cyc(20);
    key_i = 1'b1;
    wait_cyc(20);
    key_i = 1'b0;
    wait_cyc(40);
    chk("burst_repress_steps", step_cnt_o, 60);

    // Zero-length burst
    do_reset();
    mode_i = 2'b11;
    burst_len_i = 8'd0;
    key_i = 1'b1;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      wait_cyc(1);
      if (busy_o) nb++;
    end
    chk("burst_zero_busy", nb, 0);
    key_i = 1'b0;
    wait_cyc(30);
    chk("burst_zero_steps", step_cnt_o, 0);

    // Burst aborted by mode change
    do_reset();
    mode_i = 2'b11;
    burst_len_i = 8'd5;
    key_i = 1'b1;
    h = cyc;
    exp_q.push_back(h + 20);
    exp_q.push_back(h + 21);
    wait_cyc(21);
    mode_i = 2'b00;
    wait_cyc(1);
    chk("abort_busy", busy_o, 0);
    key_i = 1'b0;
    wait_cyc(30);
    chk("abort_steps", step_cnt_o, 2);

    // Snapshot
    do_reset();
    ch_sel_i = 3'd2;
    wait_cyc(1);
    chk("snap_ch2", data_o, 32'hDEAD_BEEF);
    ch_sel_i = 3'd7;
    wait_cyc(1);
    chk("snap_ch7", data_o, 0);
    ch_sel_i = 3'd3;
    wait_cyc(1);
    chk("snap_ch3", data_o, 32'h3333_3333);
    probe_i[3*DATA_W +: DATA_W] = 32'h3333_AAAA;
    wait_cyc(3);
    chk("snap_hold", data_o, 32'h3333_3333);
    freeze_i = 1'b1;
    ch_sel_i = 3'd4;
    wait_cyc(1);
    chk("snap_freeze_sel", data_o, 32'h3333_3333);
    run_for(0, 4);
    wait_cyc(1);
    chk("snap_freeze_step", data_o, 32'h3333_3333);
    freeze_i = 1'b0;
    wait_cyc(2);
    chk("snap_unfreeze_hold", data_o, 32'h3333_3333);
    run_for(0, 2);
    wait_cyc(1);
    chk("snap_step_load", data_o, 32'h4444_4444);

    // Step counter wrap
    wait_cyc(2);
    force dut.step_cnt_q = 32'hFFFF_FFFE;
    wait_cyc(1);
    release dut.step_cnt_q;
    wait_cyc(1);
    chk("wrap_preload", step_cnt_o, 32'hFFFF_FFFE);
    run_for(0, 3);
    chk("wrap_ffff", step_cnt_o, 32'hFFFF_FFFF);
    wait_cyc(1);
    chk("wrap_zero", step_cnt_o, 0);
    wait_cyc(3);
    chk("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
